// File: rtl/tinyrisc_pkg.sv
// Shared encodings for the tinyrisc control path: FSM states, opcodes, PC source select.
package tinyrisc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4,
    ST_HALT    = 3'd5,
    ST_ERROR   = 3'd6
  } state_e;

  localparam logic [4:0] OP_MUL  = 5'b00010;
  localparam logic [4:0] OP_DIV  = 5'b00011;
  localparam logic [4:0] OP_MOD  = 5'b00100;
  localparam logic [4:0] OP_NOP  = 5'b01101;
  localparam logic [4:0] OP_HALT = 5'b11111;

  localparam logic [1:0] PC_SEL_INC = 2'd0;
  localparam logic [1:0] PC_SEL_BR  = 2'd1;
  localparam logic [1:0] PC_SEL_JMP = 2'd2;

  // Opcodes that hand off to the iterative ALU and wait for alu_done.
  function automatic logic is_multicycle(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/handshake_timer.sv
// Counts consecutive unacknowledged request cycles; flags the cycle that reaches TIMEOUT.
module handshake_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt;

  // cnt holds the number of waited cycles before the current one, so the
  // TIMEOUT-th waiting cycle is the one that sees cnt == TIMEOUT-1.
  assign expired = enable && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= '0;
    else if (enable)  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM: fetch/decode/execute/mem/writeback with handshake timeouts.
module multicycle_sequencer
  import tinyrisc_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  output logic       imem_req,
  input  logic       imem_ack,
  output logic       ir_load,
  input  logic [4:0] dec_opcode,
  input  logic       dec_mem_read,
  input  logic       dec_mem_write,
  input  logic       dec_reg_write,
  input  logic       dec_branch,
  input  logic       dec_jump,
  input  logic       branch_taken,
  output logic       alu_start,
  input  logic       alu_done,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ack,
  output logic       pc_write,
  output logic [1:0] pc_sel,
  output logic       rf_write,
  output logic       halted,
  output logic       bus_error,
  output logic [2:0] state
);

  state_e     state_q, state_d;
  logic       alu_busy;
  logic       multi;
  logic       tmr_en, tmr_clear, tmr_expired;
  logic       imem_req_c, ir_load_c, alu_start_c, dmem_req_c, dmem_we_c;
  logic       pc_write_c, rf_write_c;
  logic [1:0] pc_sel_c;

  assign multi = is_multicycle(dec_opcode);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      alu_busy <= 1'b0;
    end else begin
      state_q  <= state_d;
      alu_busy <= (state_q == ST_EXECUTE) && multi && (state_d == ST_EXECUTE);
    end
  end

  always_comb begin
    state_d     = state_q;
    imem_req_c  = 1'b0;
    ir_load_c   = 1'b0;
    alu_start_c = 1'b0;
    dmem_req_c  = 1'b0;
    dmem_we_c   = 1'b0;
    pc_write_c  = 1'b0;
    pc_sel_c    = PC_SEL_INC;
    rf_write_c  = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ack) begin
          ir_load_c = 1'b1;
          state_d   = ST_DECODE;
        end else if (tmr_expired) begin
          state_d = ST_ERROR;
        end
      end
      ST_DECODE: begin
        if (dec_opcode == OP_HALT) begin
          state_d = ST_HALT;
        end else if (dec_opcode == OP_NOP) begin
          pc_write_c = 1'b1;
          state_d    = ST_FETCH;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        // Entry cycle of a multi-cycle op only launches the ALU; alu_done is not looked at.
        if (multi && !alu_busy) begin
          alu_start_c = 1'b1;
        end else if (!multi || alu_done) begin
          if (dec_mem_read || dec_mem_write) begin
            state_d = ST_MEM;
          end else if (dec_branch) begin
            pc_write_c = 1'b1;
            pc_sel_c   = branch_taken ? PC_SEL_BR : PC_SEL_INC;
            state_d    = ST_FETCH;
          end else if (dec_jump && !dec_reg_write) begin
            pc_write_c = 1'b1;
            pc_sel_c   = PC_SEL_JMP;
            state_d    = ST_FETCH;
          end else if (dec_reg_write) begin
            state_d = ST_WB;
          end else begin
            pc_write_c = 1'b1;
            state_d    = ST_FETCH;
          end
        end
      end
      ST_MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = dec_mem_write;
        if (dmem_ack) begin
          if (dec_mem_write) begin
            pc_write_c = 1'b1;
            state_d    = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (tmr_expired) begin
          state_d = ST_ERROR;
        end
      end
      ST_WB: begin
        rf_write_c = 1'b1;
        pc_write_c = 1'b1;
        pc_sel_c   = (dec_jump && dec_reg_write) ? PC_SEL_JMP : PC_SEL_INC;
        state_d    = ST_FETCH;
      end
      ST_HALT:  state_d = ST_HALT;
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_ERROR;
    endcase
  end

  // Any state change restarts the wait count, so FETCH and MEM always start from zero.
  assign tmr_clear = (state_d != state_q);
  assign tmr_en    = ((state_q == ST_FETCH) && !imem_ack) ||
                     ((state_q == ST_MEM)   && !dmem_ack);

  handshake_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clear),
    .enable  (tmr_en),
    .expired (tmr_expired)
  );

  // Reset forces every output low immediately, even mid-transaction.
  assign imem_req  = !rst && imem_req_c;
  assign ir_load   = !rst && ir_load_c;
  assign alu_start = !rst && alu_start_c;
  assign dmem_req  = !rst && dmem_req_c;
  assign dmem_we   = !rst && dmem_we_c;
  assign pc_write  = !rst && pc_write_c;
  assign pc_sel    = rst ? PC_SEL_INC : pc_sel_c;
  assign rf_write  = !rst && rf_write_c;
  assign halted    = !rst && (state_q == ST_HALT);
  assign bus_error = !rst && (state_q == ST_ERROR);
  assign state     = rst ? ST_FETCH : state_q;

endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 16, max cycles a memory request may wait for acknowledge.
REQ-002 clk  in  1  single system clock, all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 imem_req  out  1  instruction fetch request; imem_ack  in  1  fetch complete.
REQ-005 ir_load  out  1  load instruction register.
REQ-006 dec_opcode  in  5  instruction[31:27] from loaded IR.
REQ-007 dec_mem_read, dec_mem_write, dec_reg_write, dec_branch, dec_jump  in  1 each  decoder control flags.
REQ-008 branch_taken  in  1  branch condition from CMP flags.
REQ-009 alu_start  out  1  start multi-cycle ALU op; alu_done  in  1  multi-cycle result ready.
REQ-010 dmem_req  out  1  data memory request; dmem_we  out  1  write enable; dmem_ack  in  1  data access complete.
REQ-011 pc_write  out  1  update PC; pc_sel  out  2  0 = PC+4, 1 = branch target, 2 = jump target.
REQ-012 rf_write  out  1  register file write strobe.
REQ-013 halted  out  1  sticky halt; bus_error  out  1  sticky timeout error; state  out  3  current FSM state.

Function
REQ-014 States: FETCH, DECODE, EXECUTE, MEM, WB, HALT, ERROR.
REQ-015 FETCH: imem_req=1 until imem_ack sampled high; on ack, ir_load=1 that cycle, next DECODE; imem_req=0 the cycle after ack.
REQ-016 DECODE: opcode 11111 -> HALT; opcode 01101 (NOP) -> FETCH with pc_write=1, pc_sel=0; else -> EXECUTE.
REQ-017 EXECUTE, opcodes 00010/00011/00100 (MUL/DIV/MOD): alu_start single-cycle pulse on entry; remain until alu_done=1; alu_done in the entry cycle is ignored.
REQ-018 EXECUTE, other ops: single cycle; mem_read or mem_write -> MEM; branch -> FETCH with pc_write=1, pc_sel=1 if branch_taken else 0; jump -> WB if reg_write (CALL) else FETCH with pc_write=1, pc_sel=2; reg_write only -> WB; no flags (CMP) -> FETCH with pc_write=1, pc_sel=0.
REQ-019 MEM: dmem_req=1, dmem_we=dec_mem_write, held until dmem_ack; on ack, load -> WB, store -> FETCH with pc_write=1, pc_sel=0.
REQ-020 WB: rf_write=1 one cycle, pc_write=1, pc_sel=2 for CALL else 0; next FETCH.
REQ-021 pc_write pulses exactly once per retired instruction, never in HALT/ERROR.
REQ-022 Minimum latency: ALU op 4 cycles, LD 5, ST 4, branch 3, NOP 2 (zero-wait acks).
REQ-023 Timeout counter clears on entering FETCH/MEM, increments each cycle req is high without ack; reaching TIMEOUT -> ERROR, req deasserted next cycle.
REQ-024 Ack in the same cycle counter reaches TIMEOUT: ack wins, no error.
REQ-025 HALT and ERROR absorbing until rst; halted=1 in HALT, bus_error=1 in ERROR; all other outputs 0.
REQ-026 Unlisted opcodes follow decoder flags; all flags 0 treated as CMP path.

Reset
REQ-027 rst sampled high: next state FETCH, counter 0; all outputs 0 while rst high, including mid-transaction requests.
REQ-028 First cycle after rst low: imem_req=1, state=FETCH.

Structure
REQ-029 Shared package tinyrisc_pkg holds opcode constants (incl. HALT 11111, NOP 01101), state encoding, pc_sel encodings.
REQ-030 Single sub-module handshake_timer: TIMEOUT counter with clear, enable, expired output.

Verification
REQ-031 ADD, zero-wait acks -> states FETCH,DECODE,EXECUTE,WB; rf_write and pc_write (pc_sel=0) in cycle 4.
REQ-032 LD, dmem_ack 3 cycles after req -> dmem_req high 3 cycles, dmem_we=0, rf_write in following WB, total 7 cycles.
REQ-033 DIV, alu_done 5 cycles after alu_start -> alu_start one cycle, EXECUTE held 6 cycles, then WB.
REQ-034 BEQ branch_taken=1 -> pc_write=1, pc_sel=1, no rf_write; branch_taken=0 -> pc_sel=0.
REQ-035 imem_ack never asserted, TIMEOUT=16 -> ERROR after 16 request cycles, bus_error=1 sticky; ack on cycle 16 -> DECODE, no error.
REQ-036 rst asserted during MEM with dmem_req=1 -> dmem_req=0 next cycle, state FETCH after release; opcode 11111 -> halted=1, no further requests.
